// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target and the bus master.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_ACK,
        ST_WAIT
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Register-side interface of the I2C target.
// Strobe semantics: reg_we and reg_re are single-cycle pulses and never
// coincide; reg_addr/reg_wdata are valid in the reg_we cycle, and reg_rdata
// must be valid for reg_addr during the reg_re cycle (it is captured on the
// following clock edge).
interface i2c_target_if;
    import i2c_pkg::*;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       nack_o;
    i2c_state_t dbg_state;

    modport slave (
        output reg_addr, reg_wdata, reg_we, reg_re, busy, nack_o, dbg_state,
        input  reg_rdata
    );

    modport master (
        input  reg_addr, reg_wdata, reg_we, reg_re, busy, nack_o, dbg_state,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Synchronises SCL/SDA into the clk domain and derives SCL edges and
// START/STOP bus conditions from the synchronised levels.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // [0] metastability flop, [1] synchronised level, [2] previous level
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Shift pins through the synchroniser; reset to the idle-high bus level
    // so leaving reset never fabricates an edge on an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign sda_s     = sda_q[1];
    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  sda_q[2] & ~sda_q[1] & scl_q[1] & scl_q[2];
    assign stop_det  = ~sda_q[2] &  sda_q[1] & scl_q[1] & scl_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target with pointer-then-data framing exposing an 8-bit register
// space through single-cycle write/read strobes.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    i2c_target_if.slave bus
);

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    i2c_state_t state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       rw;
    logic       ack_phase;   // set while the ACK bit cell is in progress
    logic       load_pend;   // capture reg_rdata on the cycle after reg_re
    logic       sda_drive;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re, busy, nack_o;
    logic [7:0] rx_byte;

    i2c_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda     = sda_drive ? 1'b0 : 1'bz;
    assign rx_byte = {shreg[6:0], sda_s};

    assign bus.reg_addr  = reg_addr;
    assign bus.reg_wdata = reg_wdata;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;
    assign bus.busy      = busy;
    assign bus.nack_o    = nack_o;
    assign bus.dbg_state = state;

    // Protocol FSM: bus conditions take priority, then bit-level events.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= I2C_RW_WRITE;
            ack_phase <= 1'b0;
            load_pend <= 1'b0;
            sda_drive <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            nack_o    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            nack_o <= 1'b0;
            if (start_det || stop_det) begin
                state     <= start_det ? ST_ADDR : ST_IDLE;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                load_pend <= 1'b0;
                sda_drive <= 1'b0;
                busy      <= 1'b0;
            end else if (load_pend) begin
                // Present the MSB in the same SCL-low window as the read request.
                load_pend <= 1'b0;
                shreg     <= bus.reg_rdata;
                sda_drive <= ~bus.reg_rdata[7];
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shreg <= rx_byte;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                case (state)
                                    ST_ADDR: begin
                                        if (rx_byte[7:1] == DEV_ADDR) begin
                                            state <= ST_ADDR_ACK;
                                            rw    <= rx_byte[0];
                                            busy  <= 1'b1;
                                        end else begin
                                            state <= ST_WAIT;
                                        end
                                    end
                                    ST_PTR: begin
                                        reg_addr <= rx_byte;
                                        state    <= ST_PTR_ACK;
                                    end
                                    default: begin
                                        reg_wdata <= rx_byte;
                                        reg_we    <= 1'b1;
                                        state     <= ST_WDATA_ACK;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                sda_drive <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_drive <= 1'b0;
                                case (state)
                                    ST_ADDR_ACK: begin
                                        if (rw == I2C_RW_READ) begin
                                            reg_re    <= 1'b1;
                                            load_pend <= 1'b1;
                                            state     <= ST_RDATA;
                                        end else begin
                                            state <= ST_PTR;
                                        end
                                    end
                                    ST_PTR_ACK: state <= ST_WDATA;
                                    default: begin
                                        reg_addr <= reg_addr + 8'd1;
                                        state    <= ST_WDATA;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_drive <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= ST_RD_ACK;
                            end else begin
                                shreg     <= {shreg[6:0], 1'b0};
                                sda_drive <= ~shreg[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            reg_addr <= reg_addr + 8'd1;
                            if (sda_s == NACK) begin
                                nack_o <= 1'b1;
                                busy   <= 1'b0;
                                state  <= ST_WAIT;
                            end else begin
                                ack_phase <= 1'b1;
                            end
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            reg_re    <= 1'b1;
                            load_pend <= 1'b1;
                            state     <= ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) that answers the I2C master on the same two-wire bus. It decodes a 7-bit device address and exposes an 8-bit register space to local logic through a simple strobe interface. Transfers use pointer-then-data framing:
- **Write**: `[addr+W][ptr][data…]`.
- **Read**: `[addr+W][ptr]`, repeated START, `[addr+R][data…]`.

The block sits beside the master in peripheral simulation and on the chip as a local control-register front end.

## Interface
- `DEV_ADDR`, default `7'h27`: 7-bit device address. Bus bytes are `0x4E` (write) and `0x4F` (read).
- `clk` in 1: system clock. Must run at least 10× SCL frequency.
- `rst` in 1: synchronous, active-high reset.
- `scl` in 1: bus clock. Target never stretches SCL.
- `sda` inout 1: open-drain data line. Driven `0` when `sda_drive` is set, else `z`.
- `reg_addr` out 8: current register pointer.
- `reg_wdata` out 8: byte received from the master.
- `reg_we` out 1: one-cycle write strobe. `reg_addr` and `reg_wdata` are valid in the same cycle.
- `reg_re` out 1: one-cycle read request for `reg_addr`.
- `reg_rdata` in 8: read data. Sampled exactly 1 clk after `reg_re`.
- `busy` out 1: high while this target is addressed, from address ACK until STOP, START, or NACK-release.
- `nack_o` out 1: one-cycle pulse when the master NACKs a read byte.

## Operation
- **Input sync**: `scl` and `sda` each pass through a 2-flop synchronizer, then edge detection.
- **Bus conditions** (evaluated on synchronized signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing**: sample SDA on the SCL rising-edge detect; update `sda_drive` on the SCL falling-edge detect.
- **States**: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT.
  - IDLE → ADDR on START.
  - START in any state → ADDR (repeated start). Shift count resets; `reg_addr` is kept.
  - STOP in any state → IDLE, SDA released.
- **ADDR**: shift 8 bits, MSB first.
  - Match `{DEV_ADDR,R/W}` → ADDR_ACK and drive SDA low for the 9th bit.
  - Mismatch → WAIT: SDA never driven, until START or STOP.
- **Write path**:
  - W-ACK → PTR. The 8-bit pointer loads `reg_addr`. PTR_ACK drives ACK, then → WDATA.
  - Each WDATA byte: `reg_we` pulses the cycle after the 8th bit is sampled. ACK is driven. After the ACK bit, `reg_addr` increments (`0xFF` wraps to `0x00`).
- **Read path**:
  - R-ACK: `reg_re` pulses on the SCL falling edge that ends the ACK bit. `reg_rdata` is latched into the shift register 1 clk later.
  - First bit (MSB) is driven on the same falling-edge window; SDA shows `0` by driving low, `1` by releasing.
  - After 8 bits, release SDA → RD_ACK and sample the master's bit.
    - ACK (0): increment `reg_addr`, pulse `reg_re`, → RDATA.
    - NACK (1): pulse `nack_o`, → WAIT. Pointer stays incremented.
- **Reset**, including mid-transfer:
  - Next clk: `sda_drive`=0, state=IDLE, `reg_addr`=`0x00`, `reg_wdata`=`0x00`.
  - `reg_we`, `reg_re`, `busy`, `nack_o` = 0.
  - The in-progress transfer is ignored until a fresh START.

## Timing
- Start/stop/edge detection lags the pins by 3 clk.
- SDA output changes 1 clk after the internal SCL-fall detect, i.e. ≤4 clk after the pin.
- `reg_we` and `reg_re` are never asserted in the same cycle. Each is at most one pulse per byte.
- A START or STOP inside a byte aborts it:
  - Partial bytes produce no strobe.
  - A byte whose 8th bit was sampled keeps its `reg_we`.
- A glitch-free bus is assumed. No spike filter beyond the synchronizer.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum;
  - `I2C_RW_WRITE`/`I2C_RW_READ`;
  - `ACK=1'b0`/`NACK=1'b1`.
- The master reuses the same package.
- One sub-module `i2c_sync_edge`: 2-flop synchronizer plus rise/fall detect and START/STOP outputs. Instantiated once, taking both `scl` and `sda`.

## Test plan
- **Write**: master (`0x4E`, ptr `0x36`, data `0x27`) → ACK on all three bytes; `reg_we` once with `reg_addr=0x36`, `reg_wdata=0x27`; `reg_addr=0x37` after STOP.
- **Read**: ptr write `0x36`, repeated START, `0x4F` with `reg_rdata=0xA5` → `reg_re` with `reg_addr=0x36`; bus shows `0xA5`; master NACK → `nack_o` pulse; SDA released.
- **Burst write wrap**: ptr `0xFE`, data `0x11,0x22,0x33` → writes to `0xFE`, `0xFF`, `0x00`.
- **Address mismatch**: `0x50` → no ACK (SDA stays high on 9th bit); no strobes; `busy`=0.
- **Burst read**: three bytes with master ACK, ACK, NACK → three `reg_re` pulses at consecutive addresses; data matches.
- **Reset mid-byte**: `rst` during bit 4 of WDATA → SDA released within 1 clk; no `reg_we`; next START/`0x4E` transaction ACKed normally.
